// File: rtl/hmac_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hmac_req_arbiter_pkg
// Description : Shared key-system constants for the HMAC request arbiter.
//               This package holds the HMAC word and result widths, the
//               arbiter state encoding, and a helper that sizes index fields.
// Revision    : 1.0 - initial release
// ============================================================================
package hmac_req_arbiter_pkg;

    // HMAC engine data widths.
    localparam int c_word_w  = 32;
    localparam int c_value_w = 512;

    // Arbiter state encoding.
    localparam int                     c_state_w        = 3;
    localparam logic [c_state_w-1:0]   c_st_idle        = 3'd0;
    localparam logic [c_state_w-1:0]   c_st_start       = 3'd1;
    localparam logic [c_state_w-1:0]   c_st_stream      = 3'd2;
    localparam logic [c_state_w-1:0]   c_st_wait_done   = 3'd3;
    localparam logic [c_state_w-1:0]   c_st_respond     = 3'd4;

    // Returns the width of an index or counter that covers n values.
    // The result is never less than 1, so that n == 1 still gets a real field.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Round-robin priority pick. The search begins at the requester
//               after the last owner and wraps around, so every active
//               requester is served within NREQ grants.
//   i_req        - request vector, one bit per requester
//   i_last_owner - index of the previous owner
//   o_onehot     - one-hot winner (all-zero when i_req is zero)
//   o_idx        - index of the winner (zero when i_req is zero)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last_owner,
    output logic [NREQ-1:0]  o_onehot,
    output logic [IDX_W-1:0] o_idx
);

    // Index that lies 'off' positions after 'base', taken modulo NREQ.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int               off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return sum[IDX_W-1:0];
    endfunction

    // The loop scans from the lowest priority (offset NREQ, which is the last
    // owner itself) up to the highest priority (offset 1). Each later match
    // overrides the earlier ones, so the nearest active requester wins and
    // no separate "found" flag is needed.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        for (int off = NREQ; off >= 1; off--) begin
            if (i_req[wrap_idx(i_last_owner, off)]) begin
                o_onehot                                = '0;
                o_onehot[wrap_idx(i_last_owner, off)]   = 1'b1;
                o_idx                                   = wrap_idx(i_last_owner, off);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hmac_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hmac_req_arbiter
// Description : Shares one HMAC engine message port among NREQ requesters.
//               A round-robin winner is granted the port. After a one-cycle
//               start pulse, the owner's message stream is forwarded to the
//               engine. The arbiter then waits for the result, bounded by a
//               timeout, and returns the result or an error to the owner.
//   clk, rst_n          - clock and asynchronous active-low reset
//   key_valid           - PUF key ready; no grant is issued while it is low,
//                         and it aborts a running transaction when it drops
//   req                 - per-requester level request
//   req_word/valid/last - per-requester message stream (32-bit slices)
//   req_ready           - per-requester message accept
//   grant               - one-hot current owner
//   rsp_valid/error/val - response pulse to the owner, error flag, result
//   hmac_start/word/valid/last - engine command and message stream
//   hmac_ready/done/value      - engine flow control and result
//   busy                - high whenever the arbiter is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module hmac_req_arbiter
    import hmac_req_arbiter_pkg::*;
#(
    parameter int NREQ         = 2,
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     key_valid,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*c_word_w-1:0] req_word,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          grant,
    output logic [NREQ-1:0]          rsp_valid,
    output logic                     rsp_error,
    output logic [c_value_w-1:0]     rsp_value,
    output logic                     hmac_start,
    output logic [c_word_w-1:0]      hmac_word,
    output logic                     hmac_valid,
    output logic                     hmac_last,
    input  logic                     hmac_ready,
    input  logic                     hmac_done,
    input  logic [c_value_w-1:0]     hmac_value,
    output logic                     busy
);

    localparam int                 c_idx_w     = idx_width(NREQ);
    localparam int                 c_cnt_w     = idx_width(DONE_TIMEOUT);
    localparam logic [c_idx_w-1:0] c_last_init = c_idx_w'(NREQ - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max   = c_cnt_w'(DONE_TIMEOUT - 1);

    logic [c_state_w-1:0] r_state;
    logic [NREQ-1:0]      r_grant;
    logic [c_idx_w-1:0]   r_owner;
    logic [c_idx_w-1:0]   r_last_owner;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [NREQ-1:0]      r_rsp_valid;
    logic                 r_rsp_error;
    logic [c_value_w-1:0] r_rsp_value;
    logic                 r_hmac_start;

    logic [NREQ-1:0]      w_pick_onehot;
    logic [c_idx_w-1:0]   w_pick_idx;
    logic                 w_stream;
    logic [c_word_w-1:0]  w_owner_word;
    logic                 w_owner_valid;
    logic                 w_owner_last;
    logic                 w_last_beat;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (c_idx_w)
    ) u_rr_pick (
        .i_req        (req),
        .i_last_owner (r_last_owner),
        .o_onehot     (w_pick_onehot),
        .o_idx        (w_pick_idx)
    );

    // Owner stream mux. The one-hot grant register selects the slice directly,
    // so this path does not depend on the encoded owner index.
    always_comb begin
        w_owner_word  = '0;
        w_owner_valid = 1'b0;
        w_owner_last  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant[i]) begin
                w_owner_word  = req_word[c_word_w*i +: c_word_w];
                w_owner_valid = req_valid[i];
                w_owner_last  = req_last[i];
            end
        end
    end

    assign w_stream    = (r_state == c_st_stream);
    assign hmac_word   = w_stream ? w_owner_word : '0;
    assign hmac_valid  = w_stream & w_owner_valid;
    assign hmac_last   = w_stream & w_owner_last;
    assign req_ready   = r_grant & {NREQ{w_stream & hmac_ready}};
    assign w_last_beat = hmac_valid & hmac_ready & hmac_last;

    assign grant      = r_grant;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_error  = r_rsp_error;
    assign rsp_value  = r_rsp_value;
    assign hmac_start = r_hmac_start;
    assign busy       = (r_state != c_st_idle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_owner <= c_last_init;
            r_cnt        <= '0;
            r_rsp_valid  <= '0;
            r_rsp_error  <= 1'b0;
            r_rsp_value  <= '0;
            r_hmac_start <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (key_valid && (|req)) begin
                        r_grant      <= w_pick_onehot;
                        r_owner      <= w_pick_idx;
                        r_hmac_start <= 1'b1;
                        r_state      <= c_st_start;
                    end
                end

                c_st_start: begin
                    r_hmac_start <= 1'b0;
                    if (!key_valid) begin
                        r_rsp_error <= 1'b1;
                        r_rsp_valid <= r_grant;
                        r_state     <= c_st_respond;
                    end else begin
                        r_state <= c_st_stream;
                    end
                end

                c_st_stream: begin
                    if (!key_valid) begin
                        r_rsp_error <= 1'b1;
                        r_rsp_valid <= r_grant;
                        r_state     <= c_st_respond;
                    end else if (w_last_beat) begin
                        r_cnt   <= '0;
                        r_state <= c_st_wait_done;
                    end
                end

                c_st_wait_done: begin
                    // A key loss outranks a result in the same cycle, and a
                    // result outranks the timeout in the same cycle.
                    if (!key_valid) begin
                        r_rsp_error <= 1'b1;
                        r_rsp_valid <= r_grant;
                        r_state     <= c_st_respond;
                    end else if (hmac_done) begin
                        r_rsp_value <= hmac_value;
                        r_rsp_error <= 1'b0;
                        r_rsp_valid <= r_grant;
                        r_state     <= c_st_respond;
                    end else if (r_cnt == c_cnt_max) begin
                        r_rsp_error <= 1'b1;
                        r_rsp_valid <= r_grant;
                        r_state     <= c_st_respond;
                    end else begin
                        // The counter only increments below its maximum,
                        // so it saturates.
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_st_respond: begin
                    r_rsp_valid  <= '0;
                    r_last_owner <= r_owner;
                    r_grant      <= '0;
                    r_state      <= c_st_idle;
                end

                default: begin
                    r_hmac_start <= 1'b0;
                    r_rsp_valid  <= '0;
                    r_grant      <= '0;
                    r_state      <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
